// File: rtl/dmem_arbiter_if.sv
// Bundle of the IFU (m0), LSU (m1) and DataSRAM signals around dmem_arbiter.
// master: requesters plus memory model side; slave: the arbiter itself.
interface dmem_arbiter_if;
  logic        m0_req_valid;
  logic        m0_req_ready;
  logic [31:0] m0_addr;
  logic        m0_resp_valid;
  logic [31:0] m0_rdata;

  logic        m1_req_valid;
  logic        m1_req_ready;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_len;
  logic [31:0] m1_wdata;
  logic        m1_resp_valid;
  logic [31:0] m1_rdata;
  logic        m1_resp_err;

  logic        mem_load;
  logic        mem_store;
  logic [31:0] mem_addr;
  logic [31:0] mem_len;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output m0_req_valid, m0_addr,
    input  m0_req_ready, m0_resp_valid, m0_rdata,
    output m1_req_valid, m1_we, m1_addr, m1_len, m1_wdata,
    input  m1_req_ready, m1_resp_valid, m1_rdata, m1_resp_err,
    input  mem_load, mem_store, mem_addr, mem_len, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  m0_req_valid, m0_addr,
    output m0_req_ready, m0_resp_valid, m0_rdata,
    input  m1_req_valid, m1_we, m1_addr, m1_len, m1_wdata,
    output m1_req_ready, m1_resp_valid, m1_rdata, m1_resp_err,
    output mem_load, mem_store, mem_addr, mem_len, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer sharing the data SRAM port between IFU (m0) and LSU (m1).
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority m1 > m0.
module dmem_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic         clock,
  input  logic         reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [3:0] CntLast = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;  // 1: m1 owns the in-flight access
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic grant0, grant1;
  logic accept;
  logic len_ok, misaligned, req_err;

`ifdef DMEM_ARB_RR_EN
  logic last1_q, last1_d;  // 1: m1 won the most recent handshake

  always_comb begin
    grant1 = bus.m1_req_valid && (!bus.m0_req_valid || !last1_q);
    grant0 = bus.m0_req_valid && !grant1;
  end

  always_comb begin
    last1_d = last1_q;
    if (accept) last1_d = grant1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last1_q <= 1'b0;
    else        last1_q <= last1_d;
  end
`else
  always_comb begin
    grant1 = bus.m1_req_valid;
    grant0 = bus.m0_req_valid && !bus.m1_req_valid;
  end
`endif

  // Requests are only taken in IDLE and never while reset is asserted.
  assign accept = (state_q == StIdle) && reset && (grant0 || grant1);

  // With len in {1,2,4}, len-1 masks exactly the address bits that must be zero.
  assign len_ok     = (bus.m1_len == 32'd1) || (bus.m1_len == 32'd2) || (bus.m1_len == 32'd4);
  assign misaligned = (bus.m1_addr[1:0] & (bus.m1_len[1:0] - 2'd1)) != 2'b00;
  assign req_err    = !len_ok || misaligned;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = (grant1 && req_err) ? StResp : StBusy;
      StBusy:  if (cnt_q == CntLast) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch, latency counter and response capture
  always_comb begin
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept) begin
      cnt_d   = 4'd0;
      owner_d = grant1;
      err_d   = grant1 && req_err;
      rdata_d = 32'h0;
      // Rejected requests leave the memory-facing fields untouched.
      if (grant1 && !req_err) begin
        we_d    = bus.m1_we;
        addr_d  = bus.m1_addr;
        len_d   = bus.m1_len;
        wdata_d = bus.m1_wdata;
      end else if (grant0) begin
        we_d    = 1'b0;
        addr_d  = bus.m0_addr;
        len_d   = 32'd4;
        wdata_d = 32'h0;
      end
    end else if (state_q == StBusy) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd0 && !we_q) rdata_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 4'd0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      len_q   <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs
  always_comb begin
    bus.m0_req_ready  = (state_q == StIdle) && reset && grant0;
    bus.m1_req_ready  = (state_q == StIdle) && reset && grant1;
    bus.mem_load      = (state_q == StBusy) && (cnt_q == 4'd0) && !we_q;
    bus.mem_store     = (state_q == StBusy) && (cnt_q == 4'd0) && we_q;
    bus.mem_addr      = addr_q;
    bus.mem_len       = len_q;
    bus.mem_wdata     = wdata_q;
    bus.m0_resp_valid = (state_q == StResp) && !owner_q;
    bus.m1_resp_valid = (state_q == StResp) && owner_q;
    bus.m0_rdata      = bus.m0_resp_valid ? rdata_q : 32'h0;
    bus.m1_rdata      = bus.m1_resp_valid ? rdata_q : 32'h0;
    bus.m1_resp_err   = bus.m1_resp_valid && err_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level timeline model.
module tb_dmem_arbiter;

  localparam int unsigned LAT    = 3;
  localparam int          RAND_N = 300;

  typedef struct packed {
    logic [31:0] cyc;
    logic        port;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] len;
    logic [31:0] data;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          bad_cnt = 0;

  ev_t hs_q[$];
  ev_t st_q[$];
  ev_t rs_q[$];

  dmem_arbiter_if bus ();

  dmem_arbiter #(.LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : ({a[15:0], a[31:16]} ^ 32'hC3A5_5A3C);
  endfunction

  assign bus.mem_rdata = mem_fn(bus.mem_addr);

  function automatic ev_t mk(input logic [31:0] c, input logic p, input logic we,
                             input logic er, input logic [31:0] a, input logic [31:0] l,
                             input logic [31:0] d);
    ev_t e;
    e.cyc = c; e.port = p; e.we = we; e.err = er; e.addr = a; e.len = l; e.data = d;
    return e;
  endfunction

  function automatic ev_t head(input ev_t q[$]);
    ev_t e;
    e = '0;
    if (q.size() > 0) e = q[0];
    return e;
  endfunction

  // Observation log of handshakes, strobes and responses, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      if (bus.m0_req_valid && bus.m0_req_ready) hs_q.push_back(mk(cyc, 1'b0, 1'b0, 1'b0, 0, 0, 0));
      if (bus.m1_req_valid && bus.m1_req_ready) hs_q.push_back(mk(cyc, 1'b1, 1'b0, 1'b0, 0, 0, 0));
      if (bus.mem_load || bus.mem_store)
        st_q.push_back(mk(cyc, 1'b0, bus.mem_store, 1'b0, bus.mem_addr, bus.mem_len,
                          bus.mem_store ? bus.mem_wdata : 32'h0));
      if (bus.m0_resp_valid) rs_q.push_back(mk(cyc, 1'b0, 1'b0, 1'b0, 0, 0, bus.m0_rdata));
      if (bus.m1_resp_valid)
        rs_q.push_back(mk(cyc, 1'b1, 1'b0, bus.m1_resp_err, 0, 0, bus.m1_rdata));
      if ((bus.m0_req_ready && bus.m1_req_ready) || (bus.mem_load && bus.mem_store) ||
          (bus.m0_resp_valid && bus.m1_resp_valid) ||
          (bus.m0_req_ready && !bus.m0_req_valid) || (bus.m1_req_ready && !bus.m1_req_valid))
        bad_cnt <= bad_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    hs_q.delete();
    st_q.delete();
    rs_q.delete();
  endtask

  task automatic idle_inputs();
    bus.m0_req_valid = 1'b0;
    bus.m0_addr      = 32'h0;
    bus.m1_req_valid = 1'b0;
    bus.m1_we        = 1'b0;
    bus.m1_addr      = 32'h0;
    bus.m1_len       = 32'h0;
    bus.m1_wdata     = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Presents one request in the current cycle and holds it until accepted (bounded).
  task automatic issue(input logic port, input logic we, input logic [31:0] a,
                       input logic [31:0] l, input logic [31:0] wd, output int unsigned d);
    d = cyc;
    if (port) begin
      bus.m1_req_valid = 1'b1; bus.m1_we = we; bus.m1_addr = a; bus.m1_len = l;
      bus.m1_wdata = wd;
    end else begin
      bus.m0_req_valid = 1'b1; bus.m0_addr = a;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (port ? bus.m1_req_ready : bus.m0_req_ready) break;
      tick();
    end
    tick();
    bus.m0_req_valid = 1'b0;
    bus.m1_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0]   ctl;
    logic [159:0] dat;
    reset = 1'b0;
    bus.m0_req_valid = 1'b1;
    bus.m1_req_valid = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    ctl = {bus.m0_req_ready, bus.m1_req_ready, bus.m0_resp_valid, bus.m1_resp_valid,
           bus.m1_resp_err, bus.mem_load, bus.mem_store};
    dat = {bus.m0_rdata, bus.m1_rdata, bus.mem_addr, bus.mem_len, bus.mem_wdata};
    checks++;
    if (ctl !== 7'b0) begin
      errors++; $display("FAIL reset_ctl: got %b want 0", ctl);
    end
    checks++;
    if (dat !== 160'b0) begin
      errors++; $display("FAIL reset_data: got %h want 0", dat);
    end
    idle_inputs();
    reset = 1'b1;
    tick();
    @(negedge clock);
    checks++;
    if ({bus.m0_req_ready, bus.m1_req_ready} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_valid_ready: got %b want 00", {bus.m0_req_ready, bus.m1_req_ready});
    end
    tick();
  endtask

  task automatic test_m0_read();
    int unsigned d;
    ev_t         want;
    clear_logs();
    issue(1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0, d);
    repeat (LAT + 3) tick();
    want = mk(d, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    checks++;
    if (hs_q.size() != 1 || head(hs_q) !== want) begin
      errors++; $display("FAIL m0_hs: got n=%0d %h want %h", hs_q.size(), head(hs_q), want);
    end
    want = mk(d + 1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0);
    checks++;
    if (st_q.size() != 1 || head(st_q) !== want) begin
      errors++; $display("FAIL m0_strobe: got n=%0d %h want %h", st_q.size(), head(st_q), want);
    end
    want = mk(d + LAT + 1, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0413);
    checks++;
    if (rs_q.size() != 1 || head(rs_q) !== want) begin
      errors++; $display("FAIL m0_resp: got n=%0d %h want %h", rs_q.size(), head(rs_q), want);
    end
  endtask

  task automatic test_store();
    int unsigned d;
    ev_t         want;
    clear_logs();
    issue(1'b1, 1'b1, 32'h8000_1000, 32'd4, 32'hDEAD_BEEF, d);
    repeat (LAT + 3) tick();
    want = mk(d + 1, 1'b0, 1'b1, 1'b0, 32'h8000_1000, 32'd4, 32'hDEAD_BEEF);
    checks++;
    if (st_q.size() != 1 || head(st_q) !== want) begin
      errors++; $display("FAIL store_strobe: got n=%0d %h want %h", st_q.size(), head(st_q), want);
    end
    want = mk(d + LAT + 1, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0);
    checks++;
    if (rs_q.size() != 1 || head(rs_q) !== want) begin
      errors++; $display("FAIL store_resp: got n=%0d %h want %h", rs_q.size(), head(rs_q), want);
    end
  endtask

  task automatic test_error();
    logic [31:0] ta [3];
    logic [31:0] tl [3];
    int unsigned d;
    ev_t         want;
    ta = '{32'h8000_0003, 32'h8000_0000, 32'h8000_0002};
    tl = '{32'd2, 32'd3, 32'd4};
    for (int i = 0; i < 3; i++) begin
      clear_logs();
      issue(1'b1, 1'b0, ta[i], tl[i], 32'h1234_5678, d);
      repeat (4) tick();
      checks++;
      if (st_q.size() != 0) begin
        errors++; $display("FAIL err_no_strobe[%0d]: got %0d strobes want 0", i, st_q.size());
      end
      want = mk(d + 1, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0);
      checks++;
      if (rs_q.size() != 1 || head(rs_q) !== want) begin
        errors++;
        $display("FAIL err_resp[%0d]: got n=%0d %h want %h", i, rs_q.size(), head(rs_q), want);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] seq;
    logic [3:0] want;
`ifdef DMEM_ARB_RR_EN
    want = 4'b1010;
`else
    want = 4'b1111;
`endif
    do_reset();
    clear_logs();
    bus.m0_req_valid = 1'b1; bus.m0_addr = 32'h8000_0100;
    bus.m1_req_valid = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h8000_0200; bus.m1_len = 32'd4;
    for (int i = 0; i < 40 && hs_q.size() < 4; i++) tick();
    idle_inputs();
    repeat (LAT + 3) tick();
    seq = 4'b0;
    for (int i = 0; i < 4 && i < hs_q.size(); i++) seq[3 - i] = hs_q[i].port;
    checks++;
    if (hs_q.size() != 4 || seq !== want) begin
      errors++; $display("FAIL arb_order: got n=%0d seq %b want 4 grants %b", hs_q.size(), seq, want);
    end
    checks++;
    if (hs_q.size() < 2 || hs_q[1].cyc - hs_q[0].cyc != LAT + 2) begin
      errors++; $display("FAIL arb_spacing: got n=%0d want gap %0d", hs_q.size(), LAT + 2);
    end
  endtask

  task automatic test_reset_busy();
    int unsigned  d;
    logic [6:0]   ctl;
    logic [159:0] dat;
    ev_t          want;
    issue(1'b1, 1'b0, 32'h8000_0010, 32'd4, 32'h0, d);
    tick();
    reset = 1'b0;
    #1;
    ctl = {bus.m0_req_ready, bus.m1_req_ready, bus.m0_resp_valid, bus.m1_resp_valid,
           bus.m1_resp_err, bus.mem_load, bus.mem_store};
    dat = {bus.m0_rdata, bus.m1_rdata, bus.mem_addr, bus.mem_len, bus.mem_wdata};
    checks++;
    if (ctl !== 7'b0 || dat !== 160'b0) begin
      errors++; $display("FAIL busy_reset_outputs: got %b %h want 0", ctl, dat);
    end
    repeat (2) tick();
    reset = 1'b1;
    clear_logs();
    repeat (LAT + 3) tick();
    checks++;
    if (rs_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL busy_reset_dropped: got %0d resp %0d strobes want 0", rs_q.size(), st_q.size());
    end
    issue(1'b0, 1'b0, 32'h8000_0020, 32'd4, 32'h0, d);
    repeat (LAT + 3) tick();
    want = mk(d + LAT + 1, 1'b0, 1'b0, 1'b0, 0, 0, mem_fn(32'h8000_0020));
    checks++;
    if (rs_q.size() != 1 || head(rs_q) !== want) begin
      errors++;
      $display("FAIL busy_reset_recover: got n=%0d %h want %h", rs_q.size(), head(rs_q), want);
    end
  endtask

  task automatic test_resp_block();
    int unsigned d;
    clear_logs();
    issue(1'b1, 1'b1, 32'h8000_0040, 32'd2, 32'h0000_BEEF, d);
    repeat (LAT) tick();
    bus.m0_req_valid = 1'b1;
    bus.m0_addr      = 32'h8000_0044;
    @(negedge clock);
    checks++;
    if (bus.m0_req_ready !== 1'b0 || bus.m1_resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_block: got ready=%b resp=%b want ready=0 resp=1",
               bus.m0_req_ready, bus.m1_resp_valid);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bus.m0_req_ready !== 1'b1) begin
      errors++; $display("FAIL resp_then_accept: got ready=%b want 1", bus.m0_req_ready);
    end
    tick();
    idle_inputs();
    repeat (LAT + 3) tick();
    checks++;
    if (hs_q.size() != 2 || hs_q[hs_q.size() - 1].cyc != d + LAT + 2) begin
      errors++; $display("FAIL resp_block_hs: got n=%0d want 2 with second at %0d",
                         hs_q.size(), d + LAT + 2);
    end
  endtask

  task automatic test_random();
    logic        v0  [RAND_N];
    logic [31:0] a0  [RAND_N];
    logic        v1  [RAND_N];
    logic        we1 [RAND_N];
    logic [31:0] a1  [RAND_N];
    logic [31:0] l1  [RAND_N];
    logic [31:0] wd1 [RAND_N];
    logic [31:0] lens [6];
    logic [31:0] tmp;
    ev_t         ehs[$];
    ev_t         est[$];
    ev_t         ers[$];
    int unsigned s;
    int unsigned free;
    logic        g1;
    logic        bad;
`ifdef DMEM_ARB_RR_EN
    logic        last1;
`endif
    lens = '{32'd1, 32'd2, 32'd4, 32'd4, 32'd3, 32'd0};
    do_reset();
    clear_logs();
    s = cyc;
    for (int i = 0; i < RAND_N; i++) begin
      v0[i]  = ($urandom_range(9, 0) < 6);
      tmp    = $urandom();
      a0[i]  = tmp & 32'hFFFF_FFFC;
      v1[i]  = ($urandom_range(9, 0) < 6);
      we1[i] = 1'($urandom_range(1, 0));
      a1[i]  = $urandom();
      l1[i]  = lens[$urandom_range(5, 0)];
      wd1[i] = $urandom();
      bus.m0_req_valid = v0[i]; bus.m0_addr = a0[i];
      bus.m1_req_valid = v1[i]; bus.m1_we = we1[i]; bus.m1_addr = a1[i];
      bus.m1_len = l1[i]; bus.m1_wdata = wd1[i];
      tick();
    end
    idle_inputs();
    repeat (LAT + 4) tick();

    // Timeline model: one access at a time, the port is free again after its response.
    free = s;
`ifdef DMEM_ARB_RR_EN
    last1 = 1'b0;
`endif
    for (int i = 0; i < RAND_N; i++) begin
      int unsigned c;
      c = s + i;
      if (c >= free && (v0[i] || v1[i])) begin
`ifdef DMEM_ARB_RR_EN
        g1 = v1[i] && (!v0[i] || !last1);
        last1 = g1;
`else
        g1 = v1[i];
`endif
        ehs.push_back(mk(c, g1, 1'b0, 1'b0, 0, 0, 0));
        bad = g1 && (!(l1[i] == 1 || l1[i] == 2 || l1[i] == 4) || (a1[i] % l1[i]) != 0);
        if (bad) begin
          ers.push_back(mk(c + 1, 1'b1, 1'b0, 1'b1, 0, 0, 0));
          free = c + 2;
        end else if (g1) begin
          est.push_back(mk(c + 1, 1'b0, we1[i], 1'b0, a1[i], l1[i], we1[i] ? wd1[i] : 32'h0));
          ers.push_back(mk(c + LAT + 1, 1'b1, 1'b0, 1'b0, 0, 0, we1[i] ? 32'h0 : mem_fn(a1[i])));
          free = c + LAT + 2;
        end else begin
          est.push_back(mk(c + 1, 1'b0, 1'b0, 1'b0, a0[i], 32'd4, 32'h0));
          ers.push_back(mk(c + LAT + 1, 1'b0, 1'b0, 1'b0, 0, 0, mem_fn(a0[i])));
          free = c + LAT + 2;
        end
      end
    end

    checks++;
    if (hs_q.size() != ehs.size() || st_q.size() != est.size() || rs_q.size() != ers.size()) begin
      errors++;
      $display("FAIL rand_counts: got hs=%0d st=%0d rs=%0d want hs=%0d st=%0d rs=%0d",
               hs_q.size(), st_q.size(), rs_q.size(), ehs.size(), est.size(), ers.size());
    end
    for (int i = 0; i < ehs.size() && i < hs_q.size(); i++) begin
      checks++;
      if (hs_q[i] !== ehs[i]) begin
        errors++; $display("FAIL rand_hs[%0d]: got %h want %h", i, hs_q[i], ehs[i]);
      end
    end
    for (int i = 0; i < est.size() && i < st_q.size(); i++) begin
      checks++;
      if (st_q[i] !== est[i]) begin
        errors++; $display("FAIL rand_strobe[%0d]: got %h want %h", i, st_q[i], est[i]);
      end
    end
    for (int i = 0; i < ers.size() && i < rs_q.size(); i++) begin
      checks++;
      if (rs_q[i] !== ers[i]) begin
        errors++; $display("FAIL rand_resp[%0d]: got %h want %h", i, rs_q[i], ers[i]);
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (bad_cnt != 0) begin
      errors++;
      $display("FAIL exclusivity: got %0d cycles with dual grant/strobe/resp or unasked ready, want 0",
               bad_cnt);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_m0_read();
    test_store();
    test_error();
    test_arbitration();
    test_reset_busy();
    test_resp_block();
    test_random();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
